// File: rtl/debouncer_if.sv
// debouncer_if: bundles the raw and debounced level vectors of the debouncer.
//   glitchy_signal   [width]  synchronized but still bouncy inputs (driven by master)
//   debounced_signal [width]  clean levels (driven by the debouncer, slave side)
//   debounced_rise   [width]  one-cycle rise pulses, present only when
//                             DEBOUNCER_EDGE_EN is defined
// Modports: master = the logic feeding inputs and consuming outputs,
//           slave  = the debouncer itself.
interface debouncer_if #(
  parameter int width = 1
);
  logic [width-1:0] glitchy_signal;
  logic [width-1:0] debounced_signal;
`ifdef DEBOUNCER_EDGE_EN
  logic [width-1:0] debounced_rise;
`endif

  modport master (
    output glitchy_signal,
`ifdef DEBOUNCER_EDGE_EN
    input  debounced_rise,
`endif
    input  debounced_signal
  );

  modport slave (
    input  glitchy_signal,
`ifdef DEBOUNCER_EDGE_EN
    output debounced_rise,
`endif
    output debounced_signal
  );
endinterface

// File: rtl/debouncer.sv
// debouncer: per-bit debouncer for already-synchronized button/switch inputs.
// A shared wrapping counter produces a sample pulse once every SAMPLE_CNT_MAX
// cycles. On each pulse every bit's saturating counter either advances (input
// high, capped at PULSE_CNT_MAX) or clears (input low). A bit's output is high
// only while its counter sits at PULSE_CNT_MAX.
// Ports:
//   clk  system clock
//   rst  synchronous active-high reset
//   bus  debouncer_if.slave: glitchy_signal in, debounced_signal out
//        (plus debounced_rise out when DEBOUNCER_EDGE_EN is defined)
// Optional feature macro: DEBOUNCER_EDGE_EN adds a registered one-cycle pulse
// per bit, high in the cycle after debounced_signal rises.
// The interface instance must be built with the same width as this module.
module debouncer #(
  parameter int width          = 1,
  parameter int SAMPLE_CNT_MAX = 25000,
  parameter int PULSE_CNT_MAX  = 150
) (
  input  logic        clk,
  input  logic        rst,
  debouncer_if.slave  bus
);
  // A single-cycle period still needs a 1-bit counter that simply stays at 0.
  localparam int WRAP_W = (SAMPLE_CNT_MAX > 1) ? $clog2(SAMPLE_CNT_MAX) : 1;
  localparam int SAT_W  = $clog2(PULSE_CNT_MAX + 1);
  localparam logic [WRAP_W-1:0] WRAP_LAST = WRAP_W'(SAMPLE_CNT_MAX - 1);
  localparam logic [SAT_W-1:0]  SAT_MAX   = SAT_W'(PULSE_CNT_MAX);

  logic [WRAP_W-1:0] wrap_cnt_reg;
  logic              sample_pulse;
  logic [width-1:0]  debounced;

  assign sample_pulse = (wrap_cnt_reg == WRAP_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      wrap_cnt_reg <= '0;
    end else if (sample_pulse) begin
      wrap_cnt_reg <= '0;
    end else begin
      wrap_cnt_reg <= wrap_cnt_reg + 1'b1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < width; gi++) begin : g_bit
      logic [SAT_W-1:0] sat_reg;

      // Any low sample restarts the run; between samples the count is frozen
      // so bounces that never land on a sample point are invisible.
      always_ff @(posedge clk) begin
        if (rst) begin
          sat_reg <= '0;
        end else if (sample_pulse) begin
          if (!bus.glitchy_signal[gi]) begin
            sat_reg <= '0;
          end else if (sat_reg != SAT_MAX) begin
            sat_reg <= sat_reg + 1'b1;
          end
        end
      end

      assign debounced[gi] = (sat_reg == SAT_MAX);
    end
  endgenerate

  assign bus.debounced_signal = debounced;

`ifdef DEBOUNCER_EDGE_EN
  logic [width-1:0] prev_reg;
  logic [width-1:0] rise_reg;

  // prev_reg resets low together with the counters, so leaving reset never
  // looks like a rising edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_reg <= '0;
      rise_reg <= '0;
    end else begin
      prev_reg <= debounced;
      rise_reg <= debounced & ~prev_reg;
    end
  end

  assign bus.debounced_rise = rise_reg;
`endif
endmodule

// File: tb/tb_debouncer.sv
// tb_debouncer: table-driven, hand-sequenced and randomized checks of the
// debouncer with SAMPLE_CNT_MAX=4, PULSE_CNT_MAX=3, width=4.
// Cycle 0 is the first cycle with rst low; inputs are applied just after a
// rising edge and outputs are checked on the falling edge of the same cycle.
module tb_debouncer;
  localparam int W = 4;
  localparam int S = 4;
  localparam int P = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  debouncer_if #(.width(W)) bus ();

  debouncer #(
    .width(W),
    .SAMPLE_CNT_MAX(S),
    .PULSE_CNT_MAX(P)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: the list of values seen at sample points since reset.
  // A bit is debounced once at least P samples exist and the last P are all 1.
  int              t;
  logic [W-1:0]    samples[$];
  logic [W-1:0]    deb_d1, deb_d2;   // expected outputs one and two cycles back

  function automatic logic [W-1:0] model_out();
    logic [W-1:0] r;
    r = '0;
    if (samples.size() >= P) begin
      r = '1;
      for (int k = samples.size() - P; k < samples.size(); k++) r &= samples[k];
    end
    return r;
  endfunction

  task automatic model_reset();
    t = 0;
    samples.delete();
    deb_d1 = '0;
    deb_d2 = '0;
  endtask

  task automatic model_edge(input logic [W-1:0] in);
    deb_d2 = deb_d1;
    deb_d1 = model_out();
    if ((t % S) == S - 1) samples.push_back(in);
    if (samples.size() > P) void'(samples.pop_front());
    t++;
  endtask

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (t=%0d)", name, act, exp, t);
    end
  endtask

  // Reset for two edges; also checks outputs the cycle after rst is seen high.
  task automatic do_reset(input string name);
    rst = 1'b1;
    bus.glitchy_signal = '0;
    @(posedge clk);
    @(negedge clk);
    check({name, "_rst_deb"}, bus.debounced_signal, '0);
`ifdef DEBOUNCER_EDGE_EN
    check({name, "_rst_rise"}, bus.debounced_rise, '0);
`endif
    @(posedge clk);
    model_reset();
    #1;
    rst = 1'b0;
    $display("%s: reset released", name);
  endtask

  // One clock cycle: apply input, check against the model and optionally
  // against an explicit expectation, then advance the model across the edge.
  task automatic run_cycle(input string name, input logic [W-1:0] in,
                           input bit use_exp, input logic [W-1:0] exp,
                           input bit use_rise, input logic [W-1:0] exp_rise,
                           input bit verbose);
    bus.glitchy_signal = in;
    @(negedge clk);
    check({name, "_model"}, bus.debounced_signal, model_out());
    if (use_exp) check({name, "_exp"}, bus.debounced_signal, exp);
`ifdef DEBOUNCER_EDGE_EN
    check({name, "_rise_model"}, bus.debounced_rise, deb_d1 & ~deb_d2);
    if (use_rise) check({name, "_rise_exp"}, bus.debounced_rise, exp_rise);
`endif
    if (verbose)
      $display("%s t=%0d in=%b deb=%b", name, t, in, bus.debounced_signal);
    @(posedge clk);
    model_edge(in);
    #1;
  endtask

  typedef struct {
    logic [W-1:0] in;
    logic [W-1:0] exp;
    logic [W-1:0] exp_rise;
  } vec_t;

  vec_t vec[24];

  initial begin
    logic [W-1:0] in;
    bus.glitchy_signal = '0;
    model_reset();

    // Case 1 / 6: hold bit0 high from cycle 0; rises in cycle 12, pulse in 13.
    for (int c = 0; c < 24; c++) begin
      vec[c].in       = 4'b0001;
      vec[c].exp      = (c >= 12) ? 4'b0001 : 4'b0000;
      vec[c].exp_rise = (c == 13) ? 4'b0001 : 4'b0000;
    end
    do_reset("hold");
    for (int c = 0; c < 24; c++)
      run_cycle("hold", vec[c].in, 1'b1, vec[c].exp, 1'b1, vec[c].exp_rise, 1'b1);
    // Release, then re-assert for only two samples: no further rise pulse.
    for (int c = 0; c < 8; c++) run_cycle("rel", 4'b0000, 1'b0, '0, 1'b1, '0, 1'b1);
    for (int c = 0; c < 8; c++) run_cycle("short", 4'b0001, 1'b1, '0, 1'b1, '0, 1'b1);
    for (int c = 0; c < 4; c++) run_cycle("short0", 4'b0000, 1'b1, '0, 1'b1, '0, 1'b1);

    // Case 2: low only in sample cycle 7 -> rise at cycle 20.
    do_reset("dip");
    for (int c = 0; c < 24; c++)
      run_cycle("dip", (c == 7) ? 4'b0000 : 4'b0001, 1'b1,
                (c >= 20) ? 4'b0001 : 4'b0000, 1'b0, '0, 1'b1);

    // Case 3: output high, then toggling only between samples for 50 cycles.
    do_reset("glitch");
    for (int c = 0; c < 12; c++) run_cycle("glitch_pre", 4'b0001, 1'b0, '0, 1'b0, '0, 1'b0);
    for (int c = 12; c < 62; c++)
      run_cycle("glitch", ((c % S) == S - 1) ? 4'b0001 : {3'b000, c[0]},
                1'b1, 4'b0001, 1'b0, '0, 1'b1);

    // Case 4: drop at cycle 13 -> sample at 15 sees 0, output low from 16.
    do_reset("drop");
    for (int c = 0; c < 22; c++)
      run_cycle("drop", (c < 13) ? 4'b0001 : 4'b0000, 1'b1,
                (c >= 12 && c < 16) ? 4'b0001 : 4'b0000, 1'b0, '0, 1'b1);

    // Case 5: bit0 steady, bit2 bouncing (low at every sample point).
    do_reset("multi");
    for (int c = 0; c < 20; c++)
      run_cycle("multi", {1'b0, ~c[0], 1'b0, 1'b1}, 1'b1,
                (c >= 12) ? 4'b0001 : 4'b0000, 1'b0, '0, 1'b1);
    do_reset("multi_mid");
    for (int c = 0; c < 16; c++)
      run_cycle("multi_again", {1'b0, ~c[0], 1'b0, 1'b1}, 1'b1,
                (c >= 12) ? 4'b0001 : 4'b0000, 1'b0, '0, 1'b1);

    // Randomized: mostly-high bits with occasional drops and rare resets.
    do_reset("rand");
    for (int n = 0; n < 600; n++) begin
      for (int b = 0; b < W; b++) in[b] = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 249) == 0) do_reset("rand");
      run_cycle("rand", in, 1'b0, '0, 1'b0, '0, 1'b0);
    end
    $display("rand: 600 cycles done");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/debouncer.md
Name: debouncer

Overview:
Per-bit debouncer placed directly downstream of the 2-FF input synchronizer on the button and switch path. It takes already-synchronized but mechanically bouncy signals and emits clean levels. A shared wrapping counter generates a periodic sample pulse. On each pulse, a per-bit saturating counter accumulates consecutive high samples, and the output goes high only once that counter saturates.

Parameters:
width, 1, number of independent input bits debounced in parallel
SAMPLE_CNT_MAX, 25000, sample period in clk cycles (legal range ≥1)
PULSE_CNT_MAX, 150, consecutive high samples required before the output asserts (legal range ≥1)

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
glitchy_signal  input  width  synchronized, undebounced inputs
debounced_signal  output  width  debounced levels

Behaviour:
- Single clock domain (clk). Reset is synchronous and active-high (rst), sampled on posedge clk.
- Internal counter widths are derived with $clog2:
  - wrap counter wide enough to hold SAMPLE_CNT_MAX-1
  - saturating counters wide enough to hold PULSE_CNT_MAX
- Wrap counter:
  - 0 on reset
  - increments by 1 each cycle
  - at SAMPLE_CNT_MAX-1 it returns to 0 on the next edge
  - sample_pulse = (wrap_cnt == SAMPLE_CNT_MAX-1), combinational, high exactly 1 cycle in every SAMPLE_CNT_MAX
  - with SAMPLE_CNT_MAX=1, sample_pulse is constantly high
- Per-bit saturating counter sat[i]:
  - 0 on reset
  - when sample_pulse is high and glitchy_signal[i]=1: sat[i] <= min(sat[i]+1, PULSE_CNT_MAX); it holds at PULSE_CNT_MAX and never wraps
  - when sample_pulse is high and glitchy_signal[i]=0: sat[i] <= 0
  - when sample_pulse is low: sat[i] holds; input glitches between sample points are ignored
- debounced_signal[i] = (sat[i] == PULSE_CNT_MAX), decoded from registers.
- Reset values:
  - all counters 0
  - debounced_signal = 0 in the cycle after rst is sampled high
  - same result when rst asserts mid-operation
- Timing: cycle 0 is the first cycle with rst low. With input held high from cycle 0:
  - sample pulses occur in cycles k*SAMPLE_CNT_MAX-1, for k = 1, 2, ...
  - output rises in cycle PULSE_CNT_MAX*SAMPLE_CNT_MAX and stays high while every sample is high
- Release: a single low sample clears sat[i]. The output falls in the cycle after that sample pulse, so release latency is at most SAMPLE_CNT_MAX cycles.
- Bits are fully independent; activity on one bit never affects another.
- rst held high with sample_pulse condition met: reset wins.

Optional Feature:
DEBOUNCER_EDGE_EN
- Defined:
  - adds output port debounced_rise (width bits)
  - debounced_rise[i] is a registered one-cycle pulse, high in the cycle after debounced_signal[i] transitions 0→1
  - implemented via a prev register, reset to 0
  - no pulse on fall
  - no pulse out of reset
- Undefined: the port and its registers are absent; all other behaviour is identical.

Test Plan:
1. SAMPLE_CNT_MAX=4, PULSE_CNT_MAX=3, width=1; rst for 2 cycles, then input held 1 from cycle 0 -> debounced_signal 0 through cycle 11, 1 from cycle 12 onward.
2. Same params; input 1, but low during exactly one sample cycle (cycle 7) -> counter clears; output rises only at cycle 20, i.e. 3 further samples at cycles 11, 15, 19.
3. Same params; output high, then input toggles 1→0→1 only on non-sample cycles for 50 cycles -> output stays 1 throughout.
4. Output high, input drops to 0 at cycle 13 -> next sample at cycle 15 sees 0; output 0 from cycle 16.
5. width=4; bit0 held 1, bit2 bouncing every cycle, others 0 -> only debounced_signal[0] asserts, at cycle 12; bits 1-3 remain 0. Then assert rst mid-run -> all outputs 0 next cycle and the counting restarts from cycle 0 timing.
6. With DEBOUNCER_EDGE_EN defined, case 1 -> debounced_rise=1 only in cycle 13, 0 in every other cycle including after release and re-assert before saturation.
